// File: rtl/divider_arbiter_if.sv
// Bundle of requester-side and divider-side signals for divider_arbiter.
// The arbiter takes the slave view; requesters plus the divider take the master view.
interface divider_arbiter_if #(
    parameter int N        = 4,
    parameter int WIDTH    = 32,
    parameter int OUT_SIZE = 8
);
    logic [N-1:0]        req_valid_in;
    logic [N-1:0]        req_ready_out;
    logic [N*WIDTH-1:0]  req_dividend_in;
    logic [N*WIDTH-1:0]  req_divisor_in;
    logic [N-1:0]        resp_valid_out;
    logic [OUT_SIZE-1:0] resp_quotient_out;
    logic                resp_error_out;
    logic                resp_timeout_out;
    logic                div_valid_out;
    logic [WIDTH-1:0]    div_dividend_out;
    logic [WIDTH-1:0]    div_divisor_out;
    logic                div_rst_out;
    logic                div_valid_in;
    logic [OUT_SIZE-1:0] div_quotient_in;
    logic                div_error_in;

    modport slave (
        input  req_valid_in, req_dividend_in, req_divisor_in,
               div_valid_in, div_quotient_in, div_error_in,
        output req_ready_out, resp_valid_out, resp_quotient_out,
               resp_error_out, resp_timeout_out,
               div_valid_out, div_dividend_out, div_divisor_out, div_rst_out
    );

    modport master (
        output req_valid_in, req_dividend_in, req_divisor_in,
               div_valid_in, div_quotient_in, div_error_in,
        input  req_ready_out, resp_valid_out, resp_quotient_out,
               resp_error_out, resp_timeout_out,
               div_valid_out, div_dividend_out, div_divisor_out, div_rst_out
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one iterative signed divider between N requesters,
// with per-requester operand slots and a watchdog that resets a hung divider.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | pick next pending slot round-robin, launch it on the divider
// ISSUE   | start pulse is on the divider; arm the watchdog
// WAIT    | wait for divider result or watchdog terminal count
// DELIVER | one-cycle response pulse to owner, free its slot
module divider_arbiter #(
    parameter int N              = 4,
    parameter int WIDTH          = 32,
    parameter int OUT_SIZE       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    divider_arbiter_if.slave bus
);
    localparam int GW = $clog2(N);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t              state, state_nxt;
    logic [N-1:0]        pending;
    logic [WIDTH-1:0]    slot_dividend [N];
    logic [WIDTH-1:0]    slot_divisor  [N];
    logic [GW-1:0]       last_grant, grant, winner;
    logic [GW:0]         probe;
    logic                found;
    logic [TW-1:0]       timer;
    logic                timer_tc;

    logic                div_valid_r, div_rst_r;
    logic [WIDTH-1:0]    div_dividend_r, div_divisor_r;
    logic [N-1:0]        resp_valid_r;
    logic [OUT_SIZE-1:0] resp_quotient_r;
    logic                resp_error_r, resp_timeout_r;

    assign bus.req_ready_out     = ~pending;
    assign bus.div_valid_out     = div_valid_r;
    assign bus.div_dividend_out  = div_dividend_r;
    assign bus.div_divisor_out   = div_divisor_r;
    assign bus.div_rst_out       = div_rst_r;
    assign bus.resp_valid_out    = resp_valid_r;
    assign bus.resp_quotient_out = resp_quotient_r;
    assign bus.resp_error_out    = resp_error_r;
    assign bus.resp_timeout_out  = resp_timeout_r;

    // Watchdog counts down from TIMEOUT_CYCLES-1; zero is the terminal count.
    assign timer_tc = (TIMEOUT_CYCLES != 0) && (timer == '0);

    // Search last_grant+1 .. last_grant+N, wrapping at N without a modulo.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        probe  = '0;
        for (int k = 1; k <= N; k++) begin
            probe = {1'b0, last_grant} + (GW+1)'(k);
            if (probe >= (GW+1)'(N))
                probe = probe - (GW+1)'(N);
            if (!found && pending[probe[GW-1:0]]) begin
                found  = 1'b1;
                winner = probe[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.div_valid_in || timer_tc) state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending         <= '0;
            last_grant      <= GW'(N-1);
            grant           <= '0;
            timer           <= '0;
            div_valid_r     <= 1'b0;
            div_rst_r       <= 1'b0;
            div_dividend_r  <= '0;
            div_divisor_r   <= '0;
            resp_valid_r    <= '0;
            resp_quotient_r <= '0;
            resp_error_r    <= 1'b0;
            resp_timeout_r  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot_dividend[i] <= '0;
                slot_divisor[i]  <= '0;
            end
        end else begin
            div_valid_r  <= 1'b0;
            div_rst_r    <= 1'b0;
            resp_valid_r <= '0;

            for (int i = 0; i < N; i++) begin
                if (bus.req_valid_in[i] && !pending[i]) begin
                    pending[i]       <= 1'b1;
                    slot_dividend[i] <= bus.req_dividend_in[i*WIDTH +: WIDTH];
                    slot_divisor[i]  <= bus.req_divisor_in[i*WIDTH +: WIDTH];
                end
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant          <= winner;
                        div_valid_r    <= 1'b1;
                        div_dividend_r <= slot_dividend[winner];
                        div_divisor_r  <= slot_divisor[winner];
                    end
                end
                ISSUE: timer <= TIMER_LOAD;
                WAIT: begin
                    if (bus.div_valid_in) begin
                        resp_valid_r    <= {{(N-1){1'b0}}, 1'b1} << grant;
                        resp_quotient_r <= bus.div_quotient_in;
                        resp_error_r    <= bus.div_error_in;
                        resp_timeout_r  <= 1'b0;
                    end else if (timer_tc) begin
                        resp_valid_r    <= {{(N-1){1'b0}}, 1'b1} << grant;
                        resp_quotient_r <= '0;
                        resp_error_r    <= 1'b0;
                        resp_timeout_r  <= 1'b1;
                        div_rst_r       <= 1'b1;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                end
                DELIVER: begin
                    pending[grant] <= 1'b0;
                    last_grant     <= grant;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one signed iterative divider (repeated-subtraction type: start pulse, busy, one-cycle result-valid pulse, error flag) between N requesters.
- Captures each requester's operands into a private slot and picks a pending slot round-robin.
- Sequences one division at a time and returns the quotient to the owning requester.
- Includes a watchdog that aborts divisions exceeding a cycle budget by pulsing the divider's reset.

Parameters:
N, 4, number of requesters (2..16)
WIDTH, 32, operand width; matches the divider's WIDTH
OUT_SIZE, 8, quotient width; matches the divider's OUT_SIZE
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; 0 disables the watchdog

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
req_valid_in  input  N  per-requester request strobe
req_ready_out  output  N  per-requester slot free
req_dividend_in  input  N*WIDTH  signed dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor_in  input  N*WIDTH  signed divisors, same packing
resp_valid_out  output  N  one-hot, one-cycle result pulse to owner
resp_quotient_out  output  OUT_SIZE  signed quotient, valid with resp_valid_out
resp_error_out  output  1  divide-by-zero flag, valid with resp_valid_out
resp_timeout_out  output  1  watchdog abort flag, valid with resp_valid_out
div_valid_out  output  1  start pulse to divider
div_dividend_out  output  WIDTH  operand to divider
div_divisor_out  output  WIDTH  operand to divider
div_rst_out  output  1  active-high synchronous reset pulse to divider
div_valid_in  input  1  divider result-valid pulse
div_quotient_in  input  OUT_SIZE  divider quotient
div_error_in  input  1  divider error flag

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0 except req_ready_out = all ones;
  - pending = 0, state = IDLE, timer = 0;
  - last_grant = N-1, so requester 0 wins first.
- Slots:
  - req_ready_out[i] = ~pending[i], combinational from a register.
  - On req_valid_in[i] & req_ready_out[i] at a clock edge, latch operands i and set pending[i].
  - While pending[i] is set, req_valid_in[i] is ignored.
- Arbitration: round-robin. Search indices last_grant+1 .. last_grant+N modulo N; the first pending index wins. Evaluated only in IDLE.
- FSM:
  - IDLE: if any pending, register grant, drive div_dividend_out/div_divisor_out from the winner's slot, set div_valid_out=1, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): div_valid_out=0, timer=0, go to WAIT. Operand outputs hold until the next issue.
  - WAIT: timer increments each cycle.
    - If div_valid_in: capture div_quotient_in and div_error_in, timeout flag=0, go to DELIVER.
    - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: quotient=0, error=0, timeout flag=1, div_rst_out=1 for exactly the next cycle, go to DELIVER.
  - DELIVER (1 cycle):
    - resp_valid_out[grant]=1 with registered resp_quotient_out, resp_error_out, resp_timeout_out;
    - clear pending[grant]; last_grant <= grant; go to IDLE.
- resp_* data outputs hold their last value between pulses. resp_valid_out and div_valid_out are single-cycle pulses only.
- div_valid_in outside WAIT is ignored and must not corrupt state.
- Latency:
  - Request captured at edge T with FSM idle: div_valid_out high in cycle T+1..T+2.
  - resp_valid_out high in the cycle after div_valid_in is sampled.
  - Slot ready again one cycle after resp_valid_out.
  - Back-to-back throughput: next div_valid_out 2 cycles after div_valid_in.
- Boundary conditions:
  - Simultaneous requests: all captured in the same cycle, served in round-robin order.
  - A request arriving on the granted index during DELIVER is refused (ready low) and retried next cycle.
  - A request on a different index during any state is accepted.
- Divide-by-zero: passed through from div_error_in; the arbiter does not pre-check.
- Watchdog: div_rst_out is asserted only on timeout, never on rst_n_in. The top level ORs system reset into the divider separately.
- Async reset mid-operation drops all pending work; no responses are issued for it.

Test Plan:
- Single request, requester 2, 100/7: div_valid_out pulses once with 100,7; resp_valid_out=0100b, quotient=14, error=0, timeout=0; req_ready_out[2] low until one cycle after the response.
- All four request in the same cycle (-50/5, 9/3, 7/0, 20/-4): div issue order 0,1,2,3; responses -10, 3, 0 with error=1, -5; each resp_valid_out one-hot, one cycle.
- Fairness: requesters 0 and 1 re-request immediately after each response for 20 divisions: grants strictly alternate 0,1,0,1, with no starvation.
- TIMEOUT_CYCLES=16, divider model stalled: resp_timeout_out=1, quotient=0, div_rst_out high exactly one cycle; the next pending request issues normally afterwards.
- Stray div_valid_in pulses in IDLE and ISSUE: no resp_valid_out and no state change; the following genuine result is delivered correctly.
- Assert rst_n_in during WAIT with three slots pending: outputs clear immediately; after release req_ready_out=1111b, no responses are emitted, and the first new request goes to requester 0.
